// File: rtl/timer_pkg.sv
// Shared types and constants for the game clock and the score counter.
package timer_pkg;

    // Two BCD digits, index 1 = tens, index 0 = ones.
    typedef logic [1:0][3:0] bcd2_t;

    localparam bcd2_t BCD2_MAX  = 8'h99;
    localparam bcd2_t BCD2_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } tstate_t;

    // Binary value of a valid two-digit BCD number (0..99).
    function automatic logic [6:0] bcd2_to_bin(input bcd2_t v);
        return 7'(v[1]) * 7'd10 + 7'(v[0]);
    endfunction

endpackage

// File: rtl/bcd2_add_sat.sv
// Combinational two-digit BCD adder that saturates at 99.
// Digits above 9 on either input are treated as 9, so a malformed operand
// can never produce a non-BCD result.
module bcd2_add_sat
    import timer_pkg::*;
(
    input  bcd2_t a,
    input  bcd2_t b,
    output bcd2_t sum
);

    logic [3:0] a_ones, a_tens, b_ones, b_tens;
    logic [4:0] ones_raw, tens_raw;
    logic       carry;

    // Clamp digits, add ones with decimal carry, then tens with saturation.
    always_comb begin
        a_ones   = (a[0] > 4'd9) ? 4'd9 : a[0];
        a_tens   = (a[1] > 4'd9) ? 4'd9 : a[1];
        b_ones   = (b[0] > 4'd9) ? 4'd9 : b[0];
        b_tens   = (b[1] > 4'd9) ? 4'd9 : b[1];
        ones_raw = {1'b0, a_ones} + {1'b0, b_ones};
        carry    = (ones_raw > 5'd9);
        tens_raw = {1'b0, a_tens} + {1'b0, b_tens} + {4'b0, carry};
        // NOTE: every output gets a value on every path, otherwise a latch is inferred.
        sum[1]   = tens_raw[3:0];
        sum[0]   = carry ? 4'(ones_raw - 5'd10) : ones_raw[3:0];
        if (tens_raw > 5'd9) begin
            sum = BCD2_MAX;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD game clock: loaded by add_time, counts down one unit every
// FRAMES_PER_SEC frames while run_en is high, and latches out_of_time at 00.
// Optional macro LOW_TIME_WARN_EN builds a blinking low-time warning
// (time_warn); without it time_warn is tied low.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 30
`ifdef LOW_TIME_WARN_EN
    ,
    parameter int WARN_THRESH    = 10
`endif
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            startOfFrame,
    input  logic            run_en,
    input  logic            add_time,
    input  logic [1:0][3:0] time_to_add,
    output logic [1:0][3:0] time_digits,
    output logic            out_of_time,
    output logic            time_warn
);

    localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_SEC - 1);

    tstate_t          state, state_n;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
    bcd2_t            digits_n, dec, add_base, add_sum;
    logic             out_n, adv, tick;

    bcd2_add_sat u_add (
        .a  (add_base),
        .b  (time_to_add),
        .sum(add_sum)
    );

    // Frame advance/tick detection and BCD decrement with borrow.
    always_comb begin
        adv = startOfFrame && run_en && (state == RUN);
        tick = adv && (frame_cnt == CNT_LAST);
        dec = time_digits;
        if (tick && (time_digits != BCD2_ZERO)) begin
            if (time_digits[0] == 4'd0) begin
                dec[1] = time_digits[1] - 4'd1;
                dec[0] = 4'd9;
            end else begin
                dec[0] = time_digits[0] - 4'd1;
            end
        end
        // A load from IDLE starts from zero; in RUN the add follows the decrement.
        add_base = (state == IDLE) ? BCD2_ZERO : dec;
    end

    // Next-state and next-output logic of the IDLE/RUN/EXPIRED machine.
    always_comb begin
        state_n     = state;
        digits_n    = time_digits;
        frame_cnt_n = frame_cnt;
        out_n       = out_of_time;
        case (state)
            IDLE: begin
                if (add_time) begin
                    digits_n    = add_sum;
                    frame_cnt_n = '0;
                    if (add_sum != BCD2_ZERO) begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    frame_cnt_n = tick ? '0 : frame_cnt + 1'b1;
                end
                digits_n = add_time ? add_sum : dec;
                if (digits_n == BCD2_ZERO) begin
                    state_n = EXPIRED;
                    out_n   = 1'b1;
                end
            end
            EXPIRED: begin
                digits_n = BCD2_ZERO;
                out_n    = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, digit, frame counter and expiry registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            time_digits <= BCD2_ZERO;
            frame_cnt   <= '0;
            out_of_time <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state       <= state_n;
            time_digits <= digits_n;
            frame_cnt   <= frame_cnt_n;
            out_of_time <= out_n;
        end
    end

`ifdef LOW_TIME_WARN_EN
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FRAMES_PER_SEC / 2);

    logic blink, blink_n, warn_n;

    // Blink phase flips on reaching count 0 and the half-second point.
    always_comb begin
        blink_n = blink;
        if (adv && ((frame_cnt_n == '0) || (frame_cnt_n == CNT_HALF))) begin
            blink_n = ~blink;
        end
        warn_n = (state_n == RUN) && blink_n &&
                 (bcd2_to_bin(digits_n) < 7'(WARN_THRESH));
    end

    // Blink phase and registered warning output.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink     <= 1'b0;
            time_warn <= 1'b0;
        end else begin
            blink     <= blink_n;
            time_warn <= warn_n;
        end
    end
`else
    assign time_warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a behavioural model holding the
// clock as a plain integer is compared on every falling edge, and directed
// scenarios pin key values with literal expectations.
// Honours LOW_TIME_WARN_EN the same way the design does.
module tb_countdown_timer;
    import timer_pkg::*;

    localparam int FPS = 30;

    logic            clk = 1'b0;
    logic            resetN;
    logic            startOfFrame;
    logic            run_en;
    logic            add_time;
    logic [1:0][3:0] time_to_add;
    logic [1:0][3:0] time_digits;
    logic            out_of_time;
    logic            time_warn;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    countdown_timer dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .run_en      (run_en),
        .add_time    (add_time),
        .time_to_add (time_to_add),
        .time_digits (time_digits),
        .out_of_time (out_of_time),
        .time_warn   (time_warn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 running, 2 expired; value held as a binary integer.
    int m_mode, m_val, m_fc;
    bit m_blink, m_oot;

    function automatic int clampd(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge resetN) begin : model
        int amt, v;
        if (!resetN) begin
            m_mode = 0; m_val = 0; m_fc = 0; m_blink = 0; m_oot = 0;
        end else begin
            amt = clampd(time_to_add[1]) * 10 + clampd(time_to_add[0]);
            if (m_mode == 0) begin
                if (add_time) begin
                    m_val = (amt > 99) ? 99 : amt;
                    m_fc  = 0;
                    if (m_val > 0) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                v = m_val;
                if (startOfFrame && run_en) begin
                    m_fc = m_fc + 1;
                    if (m_fc == FPS) begin
                        m_fc = 0;
                        v = v - 1;
                        m_blink = ~m_blink;
                    end else if (m_fc == FPS / 2) begin
                        m_blink = ~m_blink;
                    end
                end
                if (add_time) v = (v + amt > 99) ? 99 : v + amt;
                m_val = v;
                if (v == 0) begin
                    m_mode = 2;
                    m_oot  = 1;
                end
            end
        end
    end

    function automatic logic exp_warn();
`ifdef LOW_TIME_WARN_EN
        return (m_mode == 1) && (m_val < 10) && m_blink;
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_digits", time_digits, to_bcd(m_val));
                check("cyc_out_of_time", out_of_time, m_oot);
                check("cyc_time_warn", time_warn, exp_warn());
            end
        end
    end

    // ---------------- stimulus helpers (all start at posedge+1) ----------------
    task automatic do_reset();
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_add(input logic [7:0] v);
        add_time = 1'b1;
        time_to_add = v;
        @(posedge clk); #1;
        add_time = 1'b0;
        time_to_add = 8'h00;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            @(posedge clk); #1;
            startOfFrame = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    logic warn_on;

    initial begin
`ifdef LOW_TIME_WARN_EN
        warn_on = 1'b1;
`else
        warn_on = 1'b0;
`endif
        resetN = 1'b0; startOfFrame = 1'b0; run_en = 1'b1;
        add_time = 1'b0; time_to_add = 8'h00;
        @(posedge clk); #1;
        do_reset();
        cmp_en = 1'b1;

        // Reset state, load 99, one tick after 30 frames.
        check("rst_digits", time_digits, 8'h00);
        check("rst_oot", out_of_time, 1'b0);
        check("rst_warn", time_warn, 1'b0);
        check("rst_state", dut.state, IDLE);
        pulse_add(8'h99);
        check("load99_digits", time_digits, 8'h99);
        check("load99_state", dut.state, RUN);
        frames(29);
        check("99_29frames", time_digits, 8'h99);
        frames(1);
        check("99_tick", time_digits, 8'h98);

        // Expiry from 02, then adds ignored.
        do_reset();
        pulse_add(8'h02);
        frames(30);
        check("02_tick1", time_digits, 8'h01);
        check("02_tick1_oot", out_of_time, 1'b0);
        frames(29);
        check("01_before_exp", time_digits, 8'h01);
        frames(1);
        check("exp_digits", time_digits, 8'h00);
        check("exp_oot", out_of_time, 1'b1);
        pulse_add(8'h10);
        check("exp_add_digits", time_digits, 8'h00);
        check("exp_add_oot", out_of_time, 1'b1);
        check("exp_state", dut.state, EXPIRED);

        // Saturation, carry, borrow, invalid digits.
        do_reset();
        pulse_add(8'h95);
        pulse_add(8'h10);
        check("sat_95_10", time_digits, 8'h99);
        do_reset();
        pulse_add(8'h19);
        pulse_add(8'h01);
        check("carry_19_01", time_digits, 8'h20);
        do_reset();
        pulse_add(8'h10);
        frames(30);
        check("borrow_10", time_digits, 8'h09);
        do_reset();
        pulse_add(8'hA3);
        check("invalid_tens", time_digits, 8'h93);
        pulse_add(8'h0F);
        check("invalid_ones_sat", time_digits, 8'h99);

        // Same-clk tick and add at 01.
        do_reset();
        pulse_add(8'h01);
        frames(29);
        startOfFrame = 1'b1; add_time = 1'b1; time_to_add = 8'h10;
        @(posedge clk); #1;
        startOfFrame = 1'b0; add_time = 1'b0; time_to_add = 8'h00;
        check("tick_add_digits", time_digits, 8'h10);
        check("tick_add_oot", out_of_time, 1'b0);

        // Freeze with run_en=0, then resume.
        do_reset();
        pulse_add(8'h50);
        run_en = 1'b0;
        frames(100);
        check("frozen_50", time_digits, 8'h50);
        pulse_add(8'h02);
        check("frozen_add", time_digits, 8'h52);
        run_en = 1'b1;
        frames(29);
        check("resume_29", time_digits, 8'h52);
        frames(1);
        check("resume_tick", time_digits, 8'h51);

        // Low-time warning blink.
        do_reset();
        pulse_add(8'h09);
        frames(14);
        check("warn_09_f14", time_warn, 1'b0);
        frames(1);
        check("warn_09_f15", time_warn, warn_on);
        frames(15);
        check("warn_08_digits", time_digits, 8'h08);
        check("warn_08_f30", time_warn, 1'b0);
        frames(15);
        check("warn_08_f45", time_warn, warn_on);
        do_reset();
        pulse_add(8'h10);
        frames(15);
        check("warn_10_off", time_warn, 1'b0);

        // Zero load stays idle and never expires.
        do_reset();
        pulse_add(8'h00);
        check("zero_state", dut.state, IDLE);
        frames(30);
        check("zero_digits", time_digits, 8'h00);
        check("zero_oot", out_of_time, 1'b0);
        pulse_add(8'h05);
        check("zero_then_05", time_digits, 8'h05);

        // Asynchronous reset mid-count.
        do_reset();
        pulse_add(8'h37);
        frames(3);
        resetN = 1'b0;
        #1;
        check("async_digits", time_digits, 8'h00);
        check("async_oot", out_of_time, 1'b0);
        check("async_state", dut.state, IDLE);
        #1;
        resetN = 1'b1;
        @(posedge clk); #1;
        frames(2);
        check("after_async", time_digits, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
